// File: rtl/ysyx_23060208_axil_arbiter.sv
// N-to-1 AXI4-Lite arbiter with one outstanding transaction; reads win over writes within the granted master.
// Define YSYX_23060208_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module ysyx_23060208_axil_arbiter #(
  parameter  int NUM_MASTERS = 2,
  parameter  int DATA_WIDTH  = 32,
  parameter  int ADDR_WIDTH  = 32,
  localparam int STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  output logic [NUM_MASTERS-1:0]            m_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_wready,
  output logic [NUM_MASTERS*2-1:0]          m_bresp,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
  output logic [NUM_MASTERS*2-1:0]          m_rresp,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic [ADDR_WIDTH-1:0]             s_awaddr,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [STRB_WIDTH-1:0]             s_wstrb,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  input  logic [1:0]                        s_bresp,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  output logic                              s_arvalid,
  input  logic                              s_arready,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic [1:0]                        s_rresp,
  input  logic                              s_rvalid,
  output logic                              s_rready
);

  localparam int GW = $clog2(NUM_MASTERS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t                   state, state_next;
  logic [GW-1:0]            grant, win;
  logic                     found, win_ar;
  logic                     aw_done, w_done, aw_hs, w_hs;
  logic [NUM_MASTERS-1:0]   req, gmask;
  logic                     sel_arvalid, sel_awvalid, sel_wvalid, sel_rready, sel_bready;
  logic [ADDR_WIDTH-1:0]    sel_araddr, sel_awaddr;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic [STRB_WIDTH-1:0]    sel_wstrb;
`ifdef YSYX_23060208_ARB_ROUND_ROBIN_EN
  logic [GW-1:0]            ptr;
`endif

  // Winner selection, evaluated only in IDLE
  always_comb begin
    req    = m_arvalid | m_awvalid;
    win    = '0;
    win_ar = 1'b0;
    found  = 1'b0;
`ifdef YSYX_23060208_ARB_ROUND_ROBIN_EN
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      int unsigned idx;
      idx = (k + 32'(ptr)) % NUM_MASTERS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        win    = GW'(idx);
        win_ar = m_arvalid[idx];
      end
    end
`else
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        win    = GW'(i);
        win_ar = m_arvalid[i];
      end
    end
`endif
  end

  always_comb begin
    sel_arvalid = 1'b0;
    sel_awvalid = 1'b0;
    sel_wvalid  = 1'b0;
    sel_rready  = 1'b0;
    sel_bready  = 1'b0;
    sel_araddr  = '0;
    sel_awaddr  = '0;
    sel_wdata   = '0;
    sel_wstrb   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant == GW'(i)) begin
        sel_arvalid = m_arvalid[i];
        sel_awvalid = m_awvalid[i];
        sel_wvalid  = m_wvalid[i];
        sel_rready  = m_rready[i];
        sel_bready  = m_bready[i];
        sel_araddr  = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_awaddr  = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata   = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb   = m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  assign gmask   = NUM_MASTERS'(1) << grant;
  assign m_rdata = {NUM_MASTERS{s_rdata}};
  assign m_rresp = {NUM_MASTERS{s_rresp}};
  assign m_bresp = {NUM_MASTERS{s_bresp}};

  // Handshake routing; AW and W stop forwarding once their done flag is set
  always_comb begin
    s_araddr  = sel_araddr;
    s_awaddr  = sel_awaddr;
    s_wdata   = sel_wdata;
    s_wstrb   = sel_wstrb;
    s_arvalid = (state == RD_ADDR) && sel_arvalid;
    m_arready = (state == RD_ADDR && s_arready) ? gmask : '0;
    s_rready  = (state == RD_DATA) && sel_rready;
    m_rvalid  = (state == RD_DATA && s_rvalid) ? gmask : '0;
    s_awvalid = (state == WR_REQ) && !aw_done && sel_awvalid;
    m_awready = (state == WR_REQ && !aw_done && s_awready) ? gmask : '0;
    s_wvalid  = (state == WR_REQ) && !w_done && sel_wvalid;
    m_wready  = (state == WR_REQ && !w_done && s_wready) ? gmask : '0;
    s_bready  = (state == WR_RESP) && sel_bready;
    m_bvalid  = (state == WR_RESP && s_bvalid) ? gmask : '0;
  end

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = win_ar ? RD_ADDR : WR_REQ;
      RD_ADDR: if (s_arvalid && s_arready) state_next = RD_DATA;
      RD_DATA: if (s_rvalid && s_rready) state_next = IDLE;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
      WR_RESP: if (s_bvalid && s_bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      grant   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef YSYX_23060208_ARB_ROUND_ROBIN_EN
      ptr     <= '0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && found) grant <= win;
      // Flags accumulate while in WR_REQ and clear on leaving it
      if (state == WR_REQ) begin
        aw_done <= (state_next == WR_REQ) && (aw_done || aw_hs);
        w_done  <= (state_next == WR_REQ) && (w_done || w_hs);
      end
`ifdef YSYX_23060208_ARB_ROUND_ROBIN_EN
      if (state != IDLE && state_next == IDLE)
        ptr <= (grant == GW'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_axil_arbiter.sv
// Directed self-checking bench for the two-master AXI4-Lite arbiter.
module tb_ysyx_23060208_axil_arbiter;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*32-1:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [N*4-1:0]  m_wstrb;
  logic [N*2-1:0]  m_bresp, m_rresp;
  logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0]     s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]      s_wstrb;
  logic [1:0]      s_bresp, s_rresp;
  logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic            s_arvalid, s_arready, s_rvalid, s_rready;

  int checks = 0;
  int failures = 0;

  ysyx_23060208_axil_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0;
    m_bready = '0; m_araddr = '0; m_arvalid = '0; m_rready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b0;
    #2;
    checks++;
    if ({m_arready, m_awready, m_wready, m_bvalid, m_rvalid} !== 10'b0) begin
      $display("FAIL reset_m_handshake got=%b exp=0", {m_arready, m_awready, m_wready, m_bvalid, m_rvalid});
      failures++;
    end
    checks++;
    if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 5'b0) begin
      $display("FAIL reset_s_handshake got=%b exp=0", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready});
      failures++;
    end
    tick(); tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read;
    m_arvalid = 2'b01;
    m_araddr[31:0] = 32'h8000_0000;
    m_rready = 2'b01;
    #1;
    checks++;
    if (s_arvalid !== 1'b0) begin
      $display("FAIL rd_idle_no_forward got=%b exp=0", s_arvalid); failures++;
    end
    tick();
    checks++;
    if ({s_arvalid, s_araddr} !== {1'b1, 32'h8000_0000}) begin
      $display("FAIL rd_ar_forward got=%b/%h exp=1/80000000", s_arvalid, s_araddr); failures++;
    end
    checks++;
    if (m_arready !== 2'b00) begin
      $display("FAIL rd_arready_wait got=%b exp=00", m_arready); failures++;
    end
    s_arready = 1'b1;
    #1;
    checks++;
    if (m_arready !== 2'b01) begin
      $display("FAIL rd_arready got=%b exp=01", m_arready); failures++;
    end
    tick();
    m_arvalid = 2'b00; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h0010_0073; s_rresp = 2'b00;
    #1;
    checks++;
    if ({m_rvalid, m_rdata[31:0], m_rresp[1:0]} !== {2'b01, 32'h0010_0073, 2'b00}) begin
      $display("FAIL rd_data got=%b/%h/%b exp=01/00100073/00", m_rvalid, m_rdata[31:0], m_rresp[1:0]); failures++;
    end
    checks++;
    if ({s_rready, m_arready[1], m_awready[1], m_wready[1], m_bvalid[1]} !== 5'b10000) begin
      $display("FAIL rd_m1_quiet got=%b exp=10000", {s_rready, m_arready[1], m_awready[1], m_wready[1], m_bvalid[1]}); failures++;
    end
    tick();
    s_rvalid = 1'b0; m_rready = 2'b00;
    #1;
    checks++;
    if ({m_rvalid, s_arvalid} !== 3'b000) begin
      $display("FAIL rd_back_idle got=%b exp=000", {m_rvalid, s_arvalid}); failures++;
    end
  endtask

  task automatic test_write_w_first;
    m_wvalid = 2'b10;
    m_wdata[63:32] = 32'hDEAD_BEEF;
    m_wstrb[7:4] = 4'hF;
    s_wready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({s_wvalid, m_wready} !== 3'b000) begin
        $display("FAIL wr_w_without_request c=%0d got=%b exp=000", c, {s_wvalid, m_wready}); failures++;
      end
      tick();
    end
    m_awvalid = 2'b10;
    m_awaddr[63:32] = 32'h8000_1000;
    #1;
    checks++;
    if (s_awvalid !== 1'b0) begin
      $display("FAIL wr_idle_no_forward got=%b exp=0", s_awvalid); failures++;
    end
    tick();
    checks++;
    if ({s_wvalid, s_wdata, s_wstrb, m_wready} !== {1'b1, 32'hDEAD_BEEF, 4'hF, 2'b10}) begin
      $display("FAIL wr_w_forward got=%b/%h/%h/%b exp=1/deadbeef/f/10", s_wvalid, s_wdata, s_wstrb, m_wready); failures++;
    end
    checks++;
    if ({s_awvalid, s_awaddr, m_awready} !== {1'b1, 32'h8000_1000, 2'b00}) begin
      $display("FAIL wr_aw_pending got=%b/%h/%b exp=1/80001000/00", s_awvalid, s_awaddr, m_awready); failures++;
    end
    tick();
    s_awready = 1'b1;
    #1;
    checks++;
    if ({s_wvalid, m_wready, m_awready} !== 5'b00010) begin
      $display("FAIL wr_w_done_aw_hs got=%b exp=00010", {s_wvalid, m_wready, m_awready}); failures++;
    end
    tick();
    m_awvalid = 2'b00; m_wvalid = 2'b00; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 2'b10;
    #1;
    checks++;
    if ({m_bvalid, m_bresp[3:2], s_bready, s_awvalid} !== 6'b10_00_1_0) begin
      $display("FAIL wr_b_route got=%b exp=100010", {m_bvalid, m_bresp[3:2], s_bready, s_awvalid}); failures++;
    end
    tick();
    s_bvalid = 1'b0; m_bready = 2'b00;
    #1;
    checks++;
    if ({m_bvalid, s_awvalid, s_wvalid} !== 4'b0000) begin
      $display("FAIL wr_back_idle got=%b exp=0000", {m_bvalid, s_awvalid, s_wvalid}); failures++;
    end
  endtask

  task automatic test_contention;
    logic [N-1:0] exp_g;
    m_arvalid = 2'b11; m_rready = 2'b11;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1111_2222;
    for (int t = 0; t < 4; t++) begin
`ifdef YSYX_23060208_ARB_ROUND_ROBIN_EN
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      tick();
      checks++;
      if (m_arready !== exp_g) begin
        $display("FAIL contention_grant t=%0d got=%b exp=%b", t, m_arready, exp_g); failures++;
      end
      tick();
      checks++;
      if (m_rvalid !== exp_g) begin
        $display("FAIL contention_rvalid t=%0d got=%b exp=%b", t, m_rvalid, exp_g); failures++;
      end
      tick();
    end
    m_arvalid = 2'b00; m_rready = 2'b00; s_arready = 1'b0; s_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_read_over_write;
    m_arvalid = 2'b01; m_awvalid = 2'b01; m_wvalid = 2'b01;
    m_araddr[31:0] = 32'h8000_0040; m_awaddr[31:0] = 32'h8000_0080;
    m_rready = 2'b01; m_bready = 2'b01;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1; s_rvalid = 1'b1; s_bvalid = 1'b1;
    tick();
    checks++;
    if ({s_arvalid, s_awvalid, s_araddr} !== {2'b10, 32'h8000_0040}) begin
      $display("FAIL row_read_first got=%b/%b/%h exp=1/0/80000040", s_arvalid, s_awvalid, s_araddr); failures++;
    end
    tick();
    m_arvalid = 2'b00;
    #1;
    checks++;
    if ({m_rvalid, s_awvalid} !== 3'b010) begin
      $display("FAIL row_rdata got=%b exp=010", {m_rvalid, s_awvalid}); failures++;
    end
    tick();
    checks++;
    if ({s_awvalid, s_arvalid} !== 2'b00) begin
      $display("FAIL row_idle got=%b exp=00", {s_awvalid, s_arvalid}); failures++;
    end
    tick();
    checks++;
    if ({s_awvalid, s_wvalid, s_awaddr} !== {2'b11, 32'h8000_0080}) begin
      $display("FAIL row_write_next got=%b/%b/%h exp=1/1/80000080", s_awvalid, s_wvalid, s_awaddr); failures++;
    end
    tick();
    m_awvalid = 2'b00; m_wvalid = 2'b00;
    #1;
    checks++;
    if (m_bvalid !== 2'b01) begin
      $display("FAIL row_bvalid got=%b exp=01", m_bvalid); failures++;
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid;
    m_arvalid = 2'b10; m_araddr[63:32] = 32'h8000_2000; m_rready = 2'b10; s_arready = 1'b1;
    tick(); tick();
    m_arvalid = 2'b00; s_rvalid = 1'b1; s_rdata = 32'hAAAA_5555;
    #1;
    checks++;
    if (m_rvalid !== 2'b10) begin
      $display("FAIL rst_pre_rvalid got=%b exp=10", m_rvalid); failures++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({m_rvalid, s_rready, m_arready, m_awready, m_wready, m_bvalid, s_arvalid, s_awvalid, s_wvalid, s_bready} !== 14'b0) begin
      $display("FAIL rst_async_clear got=%b exp=0", {m_rvalid, s_rready, m_arready, m_awready, m_wready, m_bvalid, s_arvalid, s_awvalid, s_wvalid, s_bready}); failures++;
    end
    tick();
    @(negedge clk);
    rst = 1'b1; s_rvalid = 1'b0;
    tick();
    m_arvalid = 2'b10; m_araddr[63:32] = 32'h8000_3000;
    tick();
    checks++;
    if ({s_arvalid, s_araddr, m_arready} !== {1'b1, 32'h8000_3000, 2'b10}) begin
      $display("FAIL rst_new_read_ar got=%b/%h/%b exp=1/80003000/10", s_arvalid, s_araddr, m_arready); failures++;
    end
    tick();
    m_arvalid = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({m_rvalid, m_rdata[63:32]} !== {2'b10, 32'h1234_5678}) begin
      $display("FAIL rst_new_read_r got=%b/%h exp=10/12345678", m_rvalid, m_rdata[63:32]); failures++;
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_error_resp;
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01;
    s_awready = 1'b1; s_wready = 1'b1;
    tick();
    tick();
    m_awvalid = 2'b00; m_wvalid = 2'b00;
    s_bvalid = 1'b1; s_bresp = 2'b10;
    #1;
    checks++;
    if ({m_bvalid, m_bresp[1:0]} !== {2'b01, 2'b10}) begin
      $display("FAIL err_bresp got=%b/%b exp=01/10", m_bvalid, m_bresp[1:0]); failures++;
    end
    tick();
    s_bvalid = 1'b0; m_bready = 2'b00;
    m_arvalid = 2'b10; s_arready = 1'b0;
    #1;
    checks++;
    if ({m_bvalid, s_arvalid} !== 3'b000) begin
      $display("FAIL err_idle got=%b exp=000", {m_bvalid, s_arvalid}); failures++;
    end
    tick();
    checks++;
    if ({s_arvalid, m_arready} !== 3'b100) begin
      $display("FAIL err_rearbitrate got=%b exp=100", {s_arvalid, m_arready}); failures++;
    end
    s_arready = 1'b1;
    tick();
    m_arvalid = 2'b00; s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b10;
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_w_first();
    test_contention();
    test_read_over_write();
    test_reset_mid();
    test_error_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_axil_arbiter.md
YSYX_23060208_AXIL_ARBITER -- requirements
Module: ysyx_23060208_axil_arbiter

Interface
REQ-001 SHALL provide parameter NUM_MASTERS, default 2, the number of AXI4-Lite master ports (IFU, LSU, ...); legal range 2..8.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, the data bus width; STRB_WIDTH is DATA_WIDTH/8.
REQ-003 SHALL provide parameter ADDR_WIDTH, default 32, the address width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 SHALL have the master AW group: m_awaddr in N*ADDR_WIDTH; m_awvalid in N; m_awready out N.
REQ-007 SHALL have the master W group: m_wdata in N*DATA_WIDTH; m_wstrb in N*STRB_WIDTH; m_wvalid in N; m_wready out N.
REQ-008 SHALL have the master B group: m_bresp out N*2; m_bvalid out N; m_bready in N.
REQ-009 SHALL have the master AR group: m_araddr in N*ADDR_WIDTH; m_arvalid in N; m_arready out N.
REQ-010 SHALL have the master R group: m_rdata out N*DATA_WIDTH; m_rresp out N*2; m_rvalid out N; m_rready in N.
REQ-011 SHALL have the slave side as one un-indexed AXI4-Lite master with the same five channels and widths, all prefixed s_ and with direction reversed.

Function
REQ-012 SHALL define the request of master i as m_arvalid[i] | m_awvalid[i].
REQ-013 SHALL use FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-014 SHALL, in IDLE with any request, register the grant index and go to RD_ADDR if the winner has arvalid, else WR_REQ; read wins if both are set.
REQ-015 SHALL NOT forward anything in the IDLE cycle; the slave sees the granted valid the next cycle, so arbitration latency is 1 cycle.
REQ-016 SHALL in RD_ADDR route AR of the granted master to s_; on s_arvalid&s_arready go to RD_DATA.
REQ-017 SHALL in RD_DATA route R to the granted master; on s_rvalid&m_rready go to IDLE.
REQ-018 SHALL in WR_REQ route AW and W independently, each completing once, latched by per-channel done flags; when both are done go to WR_RESP.
REQ-019 SHALL in WR_RESP route B to the granted master; on s_bvalid&m_bready go to IDLE.
REQ-020 SHALL drive every ready/valid of non-granted masters to 0 and all s_ valids to 0 in IDLE; data buses are don't-care when their valid is 0.
REQ-021 SHALL pass s_rresp and s_bresp (including SLVERR/DECERR) unmodified; at most one outstanding transaction.
REQ-022 SHALL ignore a granted master dropping its request mid-transaction; the transaction runs to completion.

Reset
REQ-023 SHALL, with rst low, force state IDLE, grant 0, priority pointer 0, done flags 0, and all m_*ready, m_*valid, s_*valid outputs 0 immediately.
REQ-024 SHALL, on reset mid-transaction, abandon the transaction; after release, arbitration restarts from IDLE.

Configuration
REQ-025 SHALL, with macro YSYX_23060208_ARB_ROUND_ROBIN_EN defined, use round-robin: search starts at the pointer, and on return to IDLE the pointer becomes (grant+1) mod NUM_MASTERS.
REQ-026 SHALL, without that macro, use fixed priority with the lowest index winning; the pointer is absent.

Verification
REQ-027 SHALL cover a single read: m0 arvalid addr 0x80000000 with slave rdata 0x00100073 -> s_arvalid one cycle later, m0 gets rdata 0x00100073 rresp 0, and m1 ready/valid stays 0.
REQ-028 SHALL cover a write with W before AW: m1 wvalid at cycle 0, awvalid 0x80001000 at cycle 3, wstrb 0xF -> W done first, AW forwarded, one B to m1 with bresp 0.
REQ-029 SHALL cover contention: m0 and m1 request reads continuously -> with the macro, grants alternate m0,m1,m0,m1; without it, m0 is always granted.
REQ-030 SHALL cover read-over-write: one master asserts arvalid and awvalid together -> read completes first, then the write is granted.
REQ-031 SHALL cover reset: rst low during RD_DATA with s_rvalid pending -> all valids/readys 0 asynchronously; after release, a new m1 read completes normally.
REQ-032 SHALL cover an error response: slave returns bresp 2'b10 -> m0 sees bresp 2'b10, and the FSM returns to IDLE.
